// File: rtl/hs_pkg.sv
// Shared definitions for the valid/data handshake link.
// Holds the default beat width, FIFO depth and counter width, the beat type
// and the data value presented while no beat is available.
package hs_pkg;

   localparam int HS_DATA_W = 3;
   localparam int HS_DEPTH  = 4;
   localparam int HS_CNT_W  = 8;

   typedef logic [HS_DATA_W-1:0] beat_t;

   // Value driven on the consumer data lines whenever the FIFO is empty.
   localparam beat_t BEAT_RST = '0;

endpackage

// File: rtl/slave_rx_if.sv
// Handshake bundle around slave_rx.
// Signals:
//   valid_up/data_up  upstream beat offered to the receiver
//   ready_up          receiver accept back to upstream
//   valid_out/data_out FIFO head offered to the local consumer
//   ready_in          consumer accept
// Handshake rule, on both pairs: a beat transfers at a rising clock edge
// where valid and ready are both 1. Once valid is raised it must stay
// raised, with data unchanged, until that transfer happens.
// Modports:
//   slave   the receiver (slave_rx)
//   master  the environment around it: upstream sender plus local consumer
interface slave_rx_if
   import hs_pkg::*;
#(
   parameter int DATA_W = HS_DATA_W
);

   logic              valid_up;
   logic [DATA_W-1:0] data_up;
   logic              ready_up;
   logic              valid_out;
   logic [DATA_W-1:0] data_out;
   logic              ready_in;

   modport slave (
      input  valid_up, data_up, ready_in,
      output ready_up, valid_out, data_out
   );

   modport master (
      output valid_up, data_up, ready_in,
      input  ready_up, valid_out, data_out
   );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: storage, read/write pointers, occupancy.
// Ports:
//   sys_clk, rst_n   clock, asynchronous active-low reset
//   i_push, i_wdata  write one beat (caller guarantees not full)
//   i_pop            drop the head beat (caller guarantees not empty)
//   o_rdata          current head entry (raw, not gated by occupancy)
//   o_occ            number of stored beats, 0..DEPTH
module sync_fifo
   import hs_pkg::*;
#(
   parameter int DATA_W = HS_DATA_W,
   parameter int DEPTH  = HS_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int OW    = AW + 1
)(
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic [OW-1:0]     o_occ
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [OW-1:0]     r_occ;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_occ   = r_occ;

endmodule

// File: rtl/slave_rx.sv
// Receive stage of the handshake link. Accepts upstream beats into a small
// FWFT FIFO, offers the FIFO head to the local consumer, counts accepted
// beats and flags upstream stability violations.
// Ports:
//   sys_clk, rst_n  clock, asynchronous active-low reset
//   bus             slave_rx_if.slave (upstream and consumer handshakes)
//   beat_cnt        accepted-beat count, wraps at 2^CNT_W
//   proto_err       sticky: upstream dropped valid or changed data while stalled
module slave_rx
   import hs_pkg::*;
#(
   parameter int DATA_W = HS_DATA_W,
   parameter int DEPTH  = HS_DEPTH,
   parameter int CNT_W  = HS_CNT_W,
   localparam int OW    = $clog2(DEPTH) + 1
)(
   input  logic             sys_clk,
   input  logic             rst_n,
   slave_rx_if.slave        bus,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             proto_err
);

   logic              r_ready_up;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic              r_proto_err;
   logic              r_last_valid;
   logic              r_last_ready;
   logic [DATA_W-1:0] r_last_data;

   logic              w_push;
   logic              w_pop;
   logic              w_valid_out;
   logic              w_viol;
   logic [DATA_W-1:0] w_head;
   logic [OW-1:0]     w_occ;
   logic [OW-1:0]     w_occ_next;

   assign w_valid_out = (w_occ != '0);
   assign w_push      = bus.valid_up & r_ready_up;
   assign w_pop       = w_valid_out & bus.ready_in;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (bus.data_up),
      .o_rdata (w_head),
      .o_occ   (w_occ)
   );

   // Occupancy after this edge; ready_up is registered from it so that a
   // pop on the filling edge reopens the link one cycle later.
   always_comb begin
      w_occ_next = w_occ;
      case ({w_push, w_pop})
         2'b10:   w_occ_next = w_occ + OW'(1);
         2'b01:   w_occ_next = w_occ - OW'(1);
         default: w_occ_next = w_occ;
      endcase
   end

   // A beat offered but not taken last cycle must still be offered, unchanged.
   assign w_viol = r_last_valid & ~r_last_ready &
                   (~bus.valid_up | (bus.data_up != r_last_data));

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready_up   <= 1'b0;
         r_beat_cnt   <= '0;
         r_proto_err  <= 1'b0;
         r_last_valid <= 1'b0;
         r_last_ready <= 1'b0;
         r_last_data  <= '0;
      end else begin
         r_ready_up   <= (w_occ_next < OW'(DEPTH));
         if (w_push) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
         if (w_viol) r_proto_err <= 1'b1;
         r_last_valid <= bus.valid_up;
         r_last_ready <= r_ready_up;
         r_last_data  <= bus.data_up;
      end
   end

   assign bus.ready_up  = r_ready_up;
   assign bus.valid_out = w_valid_out;
   assign bus.data_out  = w_valid_out ? w_head : DATA_W'(BEAT_RST);
   assign beat_cnt      = r_beat_cnt;
   assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_slave_rx.sv
// Bench for slave_rx: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the receiver.
module tb_slave_rx;
   import hs_pkg::*;

   localparam int DW    = HS_DATA_W;
   localparam int DEPTH = HS_DEPTH;
   localparam int CW    = HS_CNT_W;

   // ---------------- clock / reset ----------------
   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;
   always #5 sys_clk = ~sys_clk;

   slave_rx_if #(.DATA_W(DW)) bus ();
   logic [CW-1:0] beat_cnt;
   logic          proto_err;

   slave_rx #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .beat_cnt  (beat_cnt),
      .proto_err (proto_err)
   );

   // ---------------- scoreboard / model ----------------
   beat_t       exp_q[$];
   int unsigned m_cnt;
   logic        m_err;
   logic        m_ready;
   logic        m_prev_valid;
   logic        m_prev_ready;
   beat_t       m_prev_data;
   logic        m_push;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_cnt        = 0;
      m_err        = 1'b0;
      m_ready      = 1'b0;
      m_prev_valid = 1'b0;
      m_prev_ready = 1'b0;
      m_prev_data  = '0;
      m_push       = 1'b0;
   endtask

   task automatic check_outputs();
      check("ready_up",  32'(bus.ready_up),  32'(m_ready));
      check("valid_out", 32'(bus.valid_out), 32'(exp_q.size() != 0));
      check("data_out",  32'(bus.data_out),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      check("beat_cnt",  32'(beat_cnt),      m_cnt % (1 << CW));
      check("proto_err", 32'(proto_err),     32'(m_err));
   endtask

   // One clock: check outputs mid-cycle, advance the model at the edge,
   // return 1 time unit after the edge so the caller can drive new inputs.
   task automatic tick();
      logic push, pop, viol;
      @(negedge sys_clk);
      check_outputs();
      push = bus.valid_up & m_ready;
      pop  = (exp_q.size() != 0) & bus.ready_in;
      @(posedge sys_clk);
      if (rst_n) begin
         viol = m_prev_valid & ~m_prev_ready &
                (~bus.valid_up | (bus.data_up != m_prev_data));
         if (viol) m_err = 1'b1;
         m_prev_valid = bus.valid_up;
         m_prev_ready = m_ready;
         m_prev_data  = bus.data_up;
         if (pop) void'(exp_q.pop_front());
         if (push) begin
            exp_q.push_back(bus.data_up);
            m_cnt++;
         end
         m_ready = (exp_q.size() < DEPTH);
      end else begin
         push = 1'b0;
      end
      m_push = push;
      #1;
   endtask

   // ---------------- driver tasks ----------------
   // New random beat only when the current one was taken or none is offered.
   task automatic next_up(input int pct_valid);
      if (bus.valid_up && !m_push) return;
      bus.valid_up = ($urandom_range(0, 99) < pct_valid);
      bus.data_up  = DW'($urandom);
   endtask

   // Wait (bounded) for the offered beat to be taken, then go idle.
   task automatic release_up();
      for (int i = 0; i < 20 && bus.valid_up && !m_push; i++) tick();
      bus.valid_up = 1'b0;
   endtask

   // With the consumer stalled, push n random beats.
   task automatic fill(input int n);
      int got = 0;
      bus.ready_in = 1'b0;
      bus.valid_up = 1'b1;
      bus.data_up  = DW'($urandom);
      for (int i = 0; i < 20 && got < n; i++) begin
         tick();
         if (m_push) begin
            got++;
            bus.data_up = DW'($urandom);
         end
      end
      bus.valid_up = 1'b0;
   endtask

   task automatic drain();
      bus.ready_in = 1'b1;
      repeat (DEPTH + 2) tick();
   endtask

   // Assert reset mid-cycle, check outputs before any edge, then release.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_valid_out", 32'(bus.valid_out), 32'd0);
      check("rst_data_out",  32'(bus.data_out),  32'd0);
      check("rst_ready_up",  32'(bus.ready_up),  32'd0);
      check("rst_beat_cnt",  32'(beat_cnt),      32'd0);
      check("rst_proto_err", 32'(proto_err),     32'd0);
      model_reset();
      bus.valid_up = 1'b0;
      bus.ready_in = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.valid_up = 1'b0;
      bus.data_up  = '0;
      bus.ready_in = 1'b0;
      model_reset();
      #3;
      check_outputs();
      tick();
      rst_n = 1'b1;
      tick();
      check("ready_after_first_edge", 32'(bus.ready_up), 32'd1);

      // Short stream with the consumer always ready.
      bus.ready_in = 1'b1;
      bus.valid_up = 1'b1;
      bus.data_up  = 3'b111; tick();
      bus.data_up  = 3'b101; tick();
      bus.data_up  = 3'b110; tick();
      bus.valid_up = 1'b0;
      tick();
      tick();
      check("stream3_cnt", 32'(beat_cnt), 32'd3);

      // Five beats into a stalled consumer; fifth accepted after one pop.
      fill(DEPTH);
      bus.valid_up = 1'b1;
      bus.data_up  = 3'b011;
      repeat (3) tick();
      check("full_ready_low", 32'(bus.ready_up), 32'd0);
      bus.ready_in = 1'b1;
      tick();
      bus.ready_in = 1'b0;
      tick();
      check("fifth_accepted", 32'(m_push), 32'd1);
      bus.valid_up = 1'b0;
      drain();

      // Full FIFO, consumer ready, upstream always offering.
      fill(DEPTH);
      bus.ready_in = 1'b1;
      bus.valid_up = 1'b1;
      bus.data_up  = DW'($urandom);
      for (int i = 0; i < 12; i++) begin
         tick();
         if (m_push) bus.data_up = DW'($urandom);
      end
      release_up();
      drain();

      // Data changed while stalled raises a sticky error.
      fill(DEPTH);
      bus.valid_up = 1'b1;
      bus.data_up  = 3'b101;
      tick();
      tick();
      bus.data_up  = 3'b110;
      tick();
      tick();
      check("proto_err_set", 32'(proto_err), 32'd1);
      bus.ready_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         next_up(70);
         bus.ready_in = $urandom_range(0, 1) != 0;
      end
      check("proto_err_sticky", 32'(proto_err), 32'd1);
      do_reset();
      check("proto_err_cleared", 32'(proto_err), 32'd0);

      // 256 pushes: counter wraps, pointers wrap, order preserved.
      bus.ready_in = 1'b1;
      bus.valid_up = 1'b1;
      bus.data_up  = DW'($urandom);
      for (int i = 0; i < 400 && m_cnt < 256; i++) begin
         tick();
         if (m_push) bus.data_up = DW'($urandom);
      end
      check("cnt_wrap", 32'(beat_cnt), 32'd0);
      release_up();
      drain();

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         next_up(70);
         bus.ready_in = $urandom_range(0, 99) < 50;
         tick();
      end
      release_up();
      drain();

      // Asynchronous reset with beats buffered.
      fill(3);
      check("three_buffered", 32'(bus.valid_out), 32'd1);
      do_reset();
      repeat (3) tick();
      check("empty_after_reset", 32'(bus.valid_out), 32'd0);
      bus.ready_in = 1'b1;
      bus.valid_up = 1'b1;
      bus.data_up  = 3'b010;
      tick();
      bus.valid_up = 1'b0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/slave_rx.md
# slave_rx

Receive-side stage of the valid/data handshake link: consumes beats from the upstream master's `valid_up`/`data_up` pair, drives `ready_up` back as the accept signal, and buffers accepted beats in a small first-word-fall-through FIFO. Buffered beats are presented to the local consumer on a second valid/ready pair. The block also counts accepted beats and flags upstream stability violations for bring-up and debug.

## Interface
- `DATA_W`, 3: beat width in bits.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 8: width of the accepted-beat counter.
- `sys_clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `valid_up`  in  1  upstream beat valid.
- `data_up`  in  DATA_W  upstream beat data.
- `ready_up`  out  1  accept; flop-driven.
- `valid_out`  out  1  FIFO head valid to consumer.
- `data_out`  out  DATA_W  FIFO head data.
- `ready_in`  in  1  consumer accept.
- `beat_cnt`  out  CNT_W  accepted-beat count, wrapping.
- `proto_err`  out  1  sticky upstream stability violation.

## Operation
- Reset (`rst_n` low, asynchronous) sets every output and internal register to its reset value:
  - occupancy 0, read pointer 0, write pointer 0;
  - `ready_up` 0, `valid_out` 0, `data_out` 0;
  - `beat_cnt` 0, `proto_err` 0.
- Reset asserted mid-transfer discards all buffered beats. No partial state survives.
- Push = `valid_up & ready_up` at a clock edge. Pop = `valid_out & ready_in` at a clock edge.
- Occupancy update:
  - push only: +1;
  - pop only: −1;
  - push and pop together: unchanged, with both pointers advancing.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- `ready_up` is a register. Its next value is 1 iff the next occupancy is below DEPTH. A pop in the same cycle as the FIFO becomes full therefore reopens `ready_up` on the following cycle, with no bubble beyond that.
- `ready_up` is never 1 while occupancy equals DEPTH. A push into a full FIFO is impossible by construction.
- `valid_out` = (occupancy ≠ 0). `data_out` = FIFO head when `valid_out` is 1, else 0.
- `beat_cnt` increments by 1 on every push and wraps from 2^CNT_W−1 to 0.
- Stability check:
  - When `valid_up` was 1 and `ready_up` was 0 in the previous cycle, `valid_up` must still be 1 and `data_up` unchanged in the current cycle.
  - Any violation sets `proto_err` to 1 on the next edge.
  - `proto_err` clears only on reset.
- Beat data is stored unmodified. No reordering, no drops.

## Timing
- Latency: a beat pushed at edge N appears on `data_out`, with `valid_out` = 1, after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: one beat per cycle sustained when the consumer holds `ready_in` at 1.
- First cycle after reset release: `ready_up` rises at the first edge, so the earliest accepted beat is at the second edge.
- Full boundary: after DEPTH pushes with no pop, `ready_up` is 0 in the cycle following the DEPTH-th push. Upstream must hold its beat.
- Empty boundary: a pop of the last entry drives `valid_out` to 0 and `data_out` to 0 in the next cycle, unless a push occurred at the same edge.
- Empty with simultaneous push: no pop is possible because `valid_out` is 0. Occupancy becomes 1.
- Full with `ready_in` = 1: a pop occurs and `ready_up` returns to 1 next cycle.

## Structure
- Shared package `hs_pkg`:
  - localparams for the default `DATA_W` (3) and `DEPTH` (4);
  - the beat typedef `beat_t` as logic [DATA_W−1:0];
  - the reset data constant 0.
- One sub-module, `sync_fifo`, owns:
  - storage array, pointers and occupancy;
  - interface: push, pop, wdata, rdata, occupancy out; `sys_clk`/`rst_n`.
- `slave_rx` owns the `ready_up` register, `beat_cnt`, the stability checker (last `valid_up`/`ready_up`/`data_up` registers) and the output gating.

## Test plan
- Reset then stream 111, 101, 110 with `ready_in` = 1:
  - `ready_up` = 1 from the first edge;
  - `data_out` shows 111, 101, 110 on consecutive cycles, each one cycle after its push;
  - `beat_cnt` = 3.
- Stream 5 beats with `ready_in` = 0 (DEPTH = 4):
  - 4 pushes accepted, then `ready_up` = 0;
  - the 5th beat is held by upstream and accepted one cycle after `ready_in` pulses 1 for one cycle.
- Full FIFO with simultaneous pop and held `valid_up`: occupancy goes 4→3→4, `ready_up` toggles 0→1→0, and no beat is lost or duplicated.
- Upstream changes `data_up` from 101 to 110 while stalled (`ready_up` = 0): `proto_err` = 1 next cycle and remains 1 through further traffic until `rst_n` pulses low.
- Push 256 beats: `beat_cnt` wraps to 0; occupancy and pointers wrap correctly with data order preserved.
- Assert `rst_n` low asynchronously with 3 beats buffered:
  - all outputs are at reset values immediately, before the next edge;
  - after release, `valid_out` stays 0 until a new push.
